row_scan_controller: RTL and testbench

- Row-level sequencer directly downstream of the 32-column shift stage (columnFiller) on the RGB matrix driver.
- Drives the column stage's enable and consumes its `filled` indication.
- Generates the matrix blanking (`oe_n`), latch (`lat`) and 4-bit row address.
- Overlaps the shift-in of row n+1 with the display of row n. Tells the upstream colour source which row pair to supply.

---
 rtl/row_scan_controller.sv | 158 +++++++++++++++
 tb/tb_row_scan_controller.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/row_scan_controller.sv
// rtl/row_scan_controller.sv - row sequencer for an RGB matrix: overlaps next-row fill with blank/latch/display of the current row
module row_scan_controller #(
  parameter int ROW_W          = 4,
  parameter int BLANK_CYCLES   = 2,
  parameter int LATCH_CYCLES   = 1,
  parameter int DISPLAY_CYCLES = 256,
  parameter int FILL_GUARD     = 2,
  parameter int FILL_TIMEOUT   = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             filled,
  output logic             fill_en,
  output logic [ROW_W-1:0] row_sel,
  output logic [ROW_W-1:0] row_addr,
  output logic             lat,
  output logic             oe_n,
  output logic             frame_start,
  output logic             fill_err
);

  localparam int CMAX0 = (DISPLAY_CYCLES > BLANK_CYCLES) ? DISPLAY_CYCLES : BLANK_CYCLES;
  localparam int CMAX  = (CMAX0 > LATCH_CYCLES) ? CMAX0 : LATCH_CYCLES;
  localparam int CW    = $clog2(CMAX + 1);
  localparam int FW    = $clog2(FILL_TIMEOUT + 1);

  localparam logic [CW-1:0]    BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0]    LATCH_LAST = CW'(LATCH_CYCLES - 1);
  localparam logic [CW-1:0]    DISP_LAST  = CW'(DISPLAY_CYCLES - 1);
  localparam logic [FW-1:0]    GUARD_MIN  = FW'(FILL_GUARD);
  localparam logic [FW-1:0]    TO_LAST    = FW'(FILL_TIMEOUT - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = '1;

  typedef enum logic [2:0] {IDLE, PRIME, BLANK, LATCH, DISPLAY} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [FW-1:0]    fill_cnt, fill_cnt_n;
  logic             fill_done, fill_done_n;
  logic             fill_en_n, lat_n, oe_n_n, frame_n, err_n;
  logic [ROW_W-1:0] row_sel_n, row_addr_n;
  logic             accept, timeout, fill_hit, done_now, expired;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      fill_cnt    <= '0;
      fill_done   <= 1'b0;
      fill_en     <= 1'b0;
      row_sel     <= '0;
      row_addr    <= '0;
      lat         <= 1'b0;
      oe_n        <= 1'b1;
      frame_start <= 1'b0;
      fill_err    <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      fill_cnt    <= fill_cnt_n;
      fill_done   <= fill_done_n;
      fill_en     <= fill_en_n;
      row_sel     <= row_sel_n;
      row_addr    <= row_addr_n;
      lat         <= lat_n;
      oe_n        <= oe_n_n;
      frame_start <= frame_n;
      fill_err    <= err_n;
    end
  end

  always_comb begin
    // A stale high 'filled' is ignored until the guard window has passed.
    accept      = fill_en && filled && (fill_cnt >= GUARD_MIN);
    timeout     = fill_en && !accept && (fill_cnt == TO_LAST);
    fill_hit    = accept || timeout;
    done_now    = fill_done || fill_hit;
    expired     = (cnt == DISP_LAST);
    state_n     = state;
    cnt_n       = cnt;
    fill_cnt_n  = fill_en ? fill_cnt + 1'b1 : '0;
    fill_en_n   = fill_en && !fill_hit;
    fill_done_n = done_now;
    err_n       = fill_err || timeout;
    lat_n       = lat;
    oe_n_n      = oe_n;
    frame_n     = 1'b0;
    row_sel_n   = row_sel;
    row_addr_n  = row_addr;
    case (state)
      IDLE: begin
        oe_n_n      = 1'b1;
        lat_n       = 1'b0;
        fill_en_n   = 1'b0;
        fill_done_n = 1'b0;
        if (run) begin
          state_n    = PRIME;
          fill_en_n  = 1'b1;
          fill_cnt_n = '0;
          row_sel_n  = '0;
          frame_n    = 1'b1;
        end
      end
      PRIME: begin
        if (fill_hit) begin
          state_n    = BLANK;
          cnt_n      = '0;
          row_addr_n = row_sel;
        end
      end
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_n = LATCH;
          cnt_n   = '0;
          lat_n   = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      LATCH: begin
        if (cnt == LATCH_LAST) begin
          state_n     = DISPLAY;
          cnt_n       = '0;
          lat_n       = 1'b0;
          oe_n_n      = 1'b0;
          row_sel_n   = row_sel + 1'b1;
          fill_done_n = 1'b0;
          if (run) begin
            fill_en_n  = 1'b1;
            fill_cnt_n = '0;
            frame_n    = (row_sel == ROW_LAST);
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DISPLAY: begin
        // With no fill in flight (run was low at entry) there is nothing to show next: stop.
        if (!expired) begin
          cnt_n = cnt + 1'b1;
        end else if (!run || (!fill_en && !fill_done)) begin
          state_n     = IDLE;
          oe_n_n      = 1'b1;
          fill_en_n   = 1'b0;
          fill_done_n = 1'b0;
        end else if (done_now) begin
          state_n    = BLANK;
          cnt_n      = '0;
          oe_n_n     = 1'b1;
          row_addr_n = row_sel;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_row_scan_controller.sv
// tb/tb_row_scan_controller.sv - randomized bench comparing the row sequencer against a row-timeline model
module tb_row_scan_controller;
  localparam int ROW_W = 4;
  localparam int NR    = 1 << ROW_W;
  localparam int B     = 2;
  localparam int L     = 1;
  localparam int D     = 8;
  localparam int G     = 2;
  localparam int TO    = 64;
  localparam int MAXT  = 4000;
  localparam logic [31:0] RESET_VEC = 32'h0000_0004;

  logic             clk = 1'b0;
  logic             reset, run, filled;
  logic             fill_en, lat, oe_n, frame_start, fill_err;
  logic [ROW_W-1:0] row_sel, row_addr;

  row_scan_controller #(
    .ROW_W(ROW_W), .BLANK_CYCLES(B), .LATCH_CYCLES(L),
    .DISPLAY_CYCLES(D), .FILL_GUARD(G), .FILL_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .filled(filled),
    .fill_en(fill_en), .row_sel(row_sel), .row_addr(row_addr),
    .lat(lat), .oe_n(oe_n), .frame_start(frame_start), .fill_err(fill_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int dly[64];
  bit stuck = 1'b0;
  int e_fe[MAXT], e_oe[MAXT], e_lt[MAXT], e_ra[MAXT], e_rs[MAXT], e_fs[MAXT], e_er[MAXT];
  int t_end, m_drop_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Column stage stand-in: raises 'filled' dly[n] cycles after the n-th fill_en rise.
  int f_idx, f_k, f_d;
  logic prev_fe;
  always @(negedge clk) begin
    if (!reset) begin
      f_idx   = 0;
      f_k     = 0;
      f_d     = 0;
      prev_fe = 1'b0;
      filled  = stuck;
    end else begin
      if (fill_en && !prev_fe) begin
        f_k = 0;
        f_d = dly[f_idx];
        if (f_idx < 63) f_idx++;
      end else if (fill_en) begin
        f_k++;
      end
      prev_fe = fill_en;
      filled  = stuck || (fill_en && (f_k >= f_d));
    end
  end

  function automatic logic [31:0] obs_vec();
    return {19'b0, fill_en, row_sel, row_addr, lat, oe_n, frame_start, fill_err};
  endfunction

  function automatic logic [31:0] exp_vec(input int t);
    return {19'b0, 1'(e_fe[t]), ROW_W'(e_rs[t]), ROW_W'(e_ra[t]),
            1'(e_lt[t]), 1'(e_oe[t]), 1'(e_fs[t]), 1'(e_er[t])};
  endfunction

  // Cycle index the fill is accepted at, counting the fill_en rise cycle as 0.
  function automatic int acc(input int d);
    if (d <= TO - 1) return (d > G) ? d : G;
    return TO - 1;
  endfunction

  // Lays out the expected timeline row by row: fill(prime), then per row blank, latch,
  // and a lit window of max(DISPLAY, next fill) cycles while the next row fills.
  task automatic build_model(input int nrows, input int drop_row);
    int t, a, s, lit, err_t, ra, rs;
    bit stop;
    for (int i = 0; i < MAXT; i++) begin
      e_fe[i] = 0; e_oe[i] = 1; e_lt[i] = 0; e_ra[i] = 0; e_rs[i] = 0; e_fs[i] = 0; e_er[i] = 0;
    end
    err_t    = MAXT;
    m_drop_t = -1;
    stop     = 1'b0;
    a = acc(dly[0]);
    if (dly[0] > TO - 1) err_t = a + 1;
    for (int i = 0; i <= a; i++) e_fe[i] = 1;
    e_fs[0] = 1;
    t = a + 1;
    t_end = t;
    for (int k = 0; k < nrows && !stop; k++) begin
      ra = k % NR;
      rs = k % NR;
      for (int i = 0; i < B + L; i++) begin
        e_ra[t+i] = ra;
        e_rs[t+i] = rs;
        e_lt[t+i] = (i >= B) ? 1 : 0;
      end
      s  = t + B + L;
      rs = (k + 1) % NR;
      a  = acc(dly[k+1]);
      for (int i = s; i < MAXT; i++) begin
        e_ra[i] = ra;
        e_rs[i] = rs;
      end
      e_fs[s] = (rs == 0) ? 1 : 0;
      if (k == drop_row) begin
        lit      = D;
        stop     = 1'b1;
        m_drop_t = s + 2;
        t_end    = s + D + 4;
      end else begin
        lit = (a + 1 > D) ? a + 1 : D;
        if (dly[k+1] > TO - 1 && s + a + 1 < err_t) err_t = s + a + 1;
        t_end = s + lit;
      end
      for (int i = 0; i < lit; i++) begin
        e_oe[s+i] = 0;
        e_fe[s+i] = (i <= a) ? 1 : 0;
      end
      t = s + lit;
    end
    for (int i = 0; i < MAXT; i++) e_er[i] = (i >= err_t) ? 1 : 0;
    if (t_end > MAXT - 1) t_end = MAXT - 1;
  endtask

  task automatic apply_reset(input string name);
    @(negedge clk);
    run   = 1'b0;
    reset = 1'b0;
    #1;
    check({name, "_rst_async"}, obs_vec(), RESET_VEC);
    @(negedge clk);
    check({name, "_rst_hold"}, obs_vec(), RESET_VEC);
    reset = 1'b1;
    @(negedge clk);
    check({name, "_idle"}, obs_vec(), RESET_VEC);
  endtask

  task automatic do_run(input string name, input int nrows, input int drop_row);
    build_model(nrows, drop_row);
    @(negedge clk);
    run = 1'b1;
    for (int t = 0; t < t_end; t++) begin
      @(negedge clk);
      check($sformatf("%s t=%0d", name, t), obs_vec(), exp_vec(t));
      if (t == m_drop_t) run = 1'b0;
    end
    apply_reset(name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    reset = 1'b0;
    run   = 1'b0;
    for (int i = 0; i < 64; i++) dly[i] = 5;
    repeat (3) @(negedge clk);
    check("reset_state", obs_vec(), RESET_VEC);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_run", obs_vec(), RESET_VEC);

    // first fill slow, then a fast filler across a full frame wrap
    dly[0] = 50;
    do_run("fast", 18, -1);

    for (int i = 0; i < 64; i++) dly[i] = 20;
    do_run("slow", 4, -1);

    stuck = 1'b1;
    for (int i = 0; i < 64; i++) dly[i] = 0;
    do_run("stuck", 4, -1);
    stuck = 1'b0;

    for (int i = 0; i < 64; i++) dly[i] = 1000;
    do_run("timeout", 2, -1);

    for (int i = 0; i < 64; i++) dly[i] = 10;
    do_run("drop", 4, 2);

    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 64; i++) dly[i] = $urandom_range(0, 30);
      dly[$urandom_range(1, 19)] = 70;
      do_run($sformatf("rand%0d", r), 20, -1);
    end

    for (int i = 0; i < 64; i++) dly[i] = 5;
    @(negedge clk);
    run = 1'b1;
    got = 0;
    for (int i = 0; i < 200 && got == 0; i++) begin
      @(negedge clk);
      if (lat === 1'b1) got = 1;
    end
    check("latch_seen", 32'(got), 32'd1);
    reset = 1'b0;
    #1;
    check("rst_mid_latch", obs_vec(), RESET_VEC);
    run = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("idle_after_latch_rst", obs_vec(), RESET_VEC);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
